indirect_normal_accum: RTL and testbench

- Downstream consumer of the indirect (reprojection) coefficient stage.
- Per frame, accumulates the Gauss-Newton normal equations from per-match Jacobian rows Ax/Ay and residuals diffs_x/diffs_y:
  - H = Σ(Ax·Axᵀ + Ay·Ayᵀ): 21 upper-triangle terms.
  - b = Σ(Ax·dx + Ay·dy): 6 terms.
  - Squared-error sum and match count.
- Results are presented once per frame to the pose solver.

---
 rtl/indirect_normal_accum_if.sv | 34 +++
 rtl/indirect_normal_accum.sv | 141 ++++++++++++++
 tb/tb_indirect_normal_accum.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/indirect_normal_accum_if.sv
// Bus between the indirect coefficient stage / pose solver and the
// normal-equation accumulator.
//   master: drives frame flags, sample qualifier, Ax/Ay rows and residuals;
//           receives H, b, err, cnt, busy, done.
//   slave : the accumulator (opposite directions).
interface indirect_normal_accum_if #(
  parameter int COE_BW = 42,
  parameter int ACC_BW = 64,
  parameter int CNT_BW = 20
);
  logic                     i_frame_start;
  logic                     i_frame_end;
  logic                     i_valid;
  logic signed [COE_BW-1:0] i_Ax [6];
  logic signed [COE_BW-1:0] i_Ay [6];
  logic signed [COE_BW-1:0] i_diffs_x;
  logic signed [COE_BW-1:0] i_diffs_y;
  logic signed [ACC_BW-1:0] o_H [21];
  logic signed [ACC_BW-1:0] o_b [6];
  logic signed [ACC_BW-1:0] o_err;
  logic [CNT_BW-1:0]        o_cnt;
  logic                     o_busy;
  logic                     o_done;

  modport master (
    output i_frame_start, i_frame_end, i_valid, i_Ax, i_Ay, i_diffs_x, i_diffs_y,
    input  o_H, o_b, o_err, o_cnt, o_busy, o_done
  );

  modport slave (
    input  i_frame_start, i_frame_end, i_valid, i_Ax, i_Ay, i_diffs_x, i_diffs_y,
    output o_H, o_b, o_err, o_cnt, o_busy, o_done
  );
endinterface

// File: rtl/indirect_normal_accum.sv
// Per-frame Gauss-Newton normal-equation accumulator.
// Ports:
//   i_clk  - clock
//   i_rst  - synchronous active-high reset (drops any frame in progress)
//   bus    - slave side of indirect_normal_accum_if:
//            in : i_frame_start, i_frame_end, i_valid, i_Ax[6], i_Ay[6],
//                 i_diffs_x, i_diffs_y
//            out: o_H[21] (upper triangle, row-major), o_b[6], o_err,
//                 o_cnt, o_busy, o_done
// Stage 1 registers the saturated per-sample terms and flags; stage 2 runs
// the frame FSM and the saturating accumulators.
module indirect_normal_accum #(
  parameter int COE_BW = 42,
  parameter int MUL    = 16,
  parameter int ACC_BW = 64,
  parameter int CNT_BW = 20
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  indirect_normal_accum_if.slave bus
);

  localparam int PW = 2 * COE_BW;
  localparam int SW = PW + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // (a0*b0 >>> MUL) + (a1*b1 >>> MUL) at full width, no overflow possible.
  function automatic logic signed [SW-1:0] scaled_sum(
    input logic signed [COE_BW-1:0] a0, input logic signed [COE_BW-1:0] b0,
    input logic signed [COE_BW-1:0] a1, input logic signed [COE_BW-1:0] b1);
    logic signed [PW-1:0] p0;
    logic signed [PW-1:0] p1;
    p0 = PW'(a0) * PW'(b0);
    p1 = PW'(a1) * PW'(b1);
    return SW'(p0 >>> MUL) + SW'(p1 >>> MUL);
  endfunction

  // Clamp a wide signed value into the ACC_BW range.
  function automatic logic signed [ACC_BW-1:0] sat(input logic signed [SW-1:0] s);
    logic [SW-ACC_BW:0] top;
    top = s[SW-1:ACC_BW-1];
    if (top == '0 || top == '1) return s[ACC_BW-1:0];
    else if (s[SW-1])           return {1'b1, {(ACC_BW-1){1'b0}}};
    else                        return {1'b0, {(ACC_BW-1){1'b1}}};
  endfunction

  state_t state_q, state_d;
  logic   v_q, s_q, e_q;
  logic   load, add;

  logic signed [ACC_BW-1:0] th_d [21];
  logic signed [ACC_BW-1:0] th_q [21];
  logic signed [ACC_BW-1:0] tb_d [6];
  logic signed [ACC_BW-1:0] tb_q [6];
  logic signed [ACC_BW-1:0] te_d, te_q;

  logic signed [ACC_BW-1:0] h_q [21];
  logic signed [ACC_BW-1:0] b_q [6];
  logic signed [ACC_BW-1:0] err_q;
  logic [CNT_BW-1:0]        cnt_q;

  // Stage 1 term generation
  always_comb begin
    int unsigned k;
    k = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      for (int unsigned j = i; j < 6; j++) begin
        th_d[k] = sat(scaled_sum(bus.i_Ax[i], bus.i_Ax[j], bus.i_Ay[i], bus.i_Ay[j]));
        k++;
      end
      tb_d[i] = sat(scaled_sum(bus.i_Ax[i], bus.i_diffs_x, bus.i_Ay[i], bus.i_diffs_y));
    end
    te_d = sat(scaled_sum(bus.i_diffs_x, bus.i_diffs_x, bus.i_diffs_y, bus.i_diffs_y));
  end

  always_ff @(posedge i_clk) begin
    th_q <= th_d;
    tb_q <= tb_d;
    te_q <= te_d;
  end

  // DONE behaves like IDLE towards a new start so back-to-back frames work.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    add     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (s_q) begin
          load    = 1'b1;
          state_d = e_q ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        state_d = e_q ? DONE : ACCUM;
        if (s_q)      load = 1'b1;
        else if (v_q) add  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      v_q     <= 1'b0;
      s_q     <= 1'b0;
      e_q     <= 1'b0;
      h_q     <= '{default: '0};
      b_q     <= '{default: '0};
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= bus.i_valid;
      s_q     <= bus.i_frame_start;
      e_q     <= bus.i_frame_end;
      if (load) begin
        for (int unsigned k = 0; k < 21; k++) h_q[k] <= v_q ? th_q[k] : '0;
        for (int unsigned k = 0; k < 6; k++)  b_q[k] <= v_q ? tb_q[k] : '0;
        err_q <= v_q ? te_q : '0;
        cnt_q <= v_q ? CNT_BW'(1) : '0;
      end else if (add) begin
        for (int unsigned k = 0; k < 21; k++) h_q[k] <= sat(SW'(h_q[k]) + SW'(th_q[k]));
        for (int unsigned k = 0; k < 6; k++)  b_q[k] <= sat(SW'(b_q[k]) + SW'(tb_q[k]));
        err_q <= sat(SW'(err_q) + SW'(te_q));
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_BW'(1);
      end
    end
  end

  assign bus.o_H    = h_q;
  assign bus.o_b    = b_q;
  assign bus.o_err  = err_q;
  assign bus.o_cnt  = cnt_q;
  assign bus.o_busy = (state_q == ACCUM);
  assign bus.o_done = (state_q == DONE);

endmodule

// File: tb/tb_indirect_normal_accum.sv
module tb_indirect_normal_accum;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  localparam logic signed [39:0] MAX40 = {1'b0, {39{1'b1}}};
  localparam logic signed [39:0] MIN40 = {1'b1, {39{1'b0}}};

  always #5 clk = ~clk;

  indirect_normal_accum_if #(.COE_BW(42), .ACC_BW(64), .CNT_BW(20)) bus ();
  indirect_normal_accum_if #(.COE_BW(42), .ACC_BW(40), .CNT_BW(20)) bus40 ();

  indirect_normal_accum #(.COE_BW(42), .MUL(16), .ACC_BW(64), .CNT_BW(20)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  indirect_normal_accum #(.COE_BW(42), .MUL(16), .ACC_BW(40), .CNT_BW(20)) dut40 (
    .i_clk(clk), .i_rst(rst), .bus(bus40)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_main();
    bus.i_frame_start = 0; bus.i_frame_end = 0; bus.i_valid = 0;
    for (int i = 0; i < 6; i++) begin bus.i_Ax[i] = '0; bus.i_Ay[i] = '0; end
    bus.i_diffs_x = '0; bus.i_diffs_y = '0;
  endtask

  task automatic clear_40();
    bus40.i_frame_start = 0; bus40.i_frame_end = 0; bus40.i_valid = 0;
    for (int i = 0; i < 6; i++) begin bus40.i_Ax[i] = '0; bus40.i_Ay[i] = '0; end
    bus40.i_diffs_x = '0; bus40.i_diffs_y = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_main();
    clear_40();
    repeat (3) step();
    n_assert++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.o_done); end
    n_assert++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
    n_assert++; if (bus.o_cnt !== 20'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus.o_cnt); end
    n_assert++; if (bus.o_H[0] !== 64'sd0) begin n_fail++; $display("FAIL reset_H0: got %0d expected 0", bus.o_H[0]); end
    n_assert++; if (bus.o_err !== 64'sd0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", bus.o_err); end
    rst = 0;
    step();
  endtask

  task automatic test_single();
    clear_main();
    bus.i_frame_start = 1; bus.i_frame_end = 1; bus.i_valid = 1;
    bus.i_Ax[0] = 42'sd65536; bus.i_diffs_x = 42'sd131072;
    step();
    clear_main();
    n_assert++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL single_early_done: got %b expected 0", bus.o_done); end
    step();
    n_assert++; if (bus.o_done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b expected 1", bus.o_done); end
    n_assert++; if (bus.o_H[0] !== 64'sd65536) begin n_fail++; $display("FAIL single_H00: got %0d expected 65536", bus.o_H[0]); end
    for (int k = 1; k < 21; k++) begin
      n_assert++;
      if (bus.o_H[k] !== 64'sd0) begin n_fail++; $display("FAIL single_H%0d: got %0d expected 0", k, bus.o_H[k]); end
    end
    n_assert++; if (bus.o_b[0] !== 64'sd131072) begin n_fail++; $display("FAIL single_b0: got %0d expected 131072", bus.o_b[0]); end
    n_assert++; if (bus.o_err !== 64'sd262144) begin n_fail++; $display("FAIL single_err: got %0d expected 262144", bus.o_err); end
    n_assert++; if (bus.o_cnt !== 20'd1) begin n_fail++; $display("FAIL single_cnt: got %0d expected 1", bus.o_cnt); end
    n_assert++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", bus.o_busy); end
    step();
    n_assert++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b expected 0", bus.o_done); end
    n_assert++; if (bus.o_H[0] !== 64'sd65536) begin n_fail++; $display("FAIL single_hold: got %0d expected 65536", bus.o_H[0]); end
  endtask

  // Samples at c=0,2,4 are valid; c=1,3 carry data with valid low.
  task automatic test_three_sample();
    int dones = 0;
    for (int c = 0; c < 10; c++) begin
      clear_main();
      if (c < 5) begin
        bus.i_valid       = (c % 2 == 0);
        bus.i_frame_start = (c == 0);
        bus.i_frame_end   = (c == 4);
        bus.i_Ax[1]       = (c % 2 == 0) ? 42'sd65536 : 42'sd327680;
        bus.i_Ay[2]       = 42'sd65536;
        bus.i_diffs_x     = -42'sd65536;
        bus.i_diffs_y     = -42'sd65536;
      end
      step();
      if (c == 2) begin
        n_assert++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL three_busy: got %b expected 1", bus.o_busy); end
      end
      if (bus.o_done === 1'b1) begin
        dones++;
        n_assert++; if (bus.o_H[6] !== 64'sd196608) begin n_fail++; $display("FAIL three_H11: got %0d expected 196608", bus.o_H[6]); end
        n_assert++; if (bus.o_H[11] !== 64'sd196608) begin n_fail++; $display("FAIL three_H22: got %0d expected 196608", bus.o_H[11]); end
        n_assert++; if (bus.o_H[7] !== 64'sd0) begin n_fail++; $display("FAIL three_H12: got %0d expected 0", bus.o_H[7]); end
        n_assert++; if (bus.o_b[1] !== -64'sd196608) begin n_fail++; $display("FAIL three_b1: got %0d expected -196608", bus.o_b[1]); end
        n_assert++; if (bus.o_b[2] !== -64'sd196608) begin n_fail++; $display("FAIL three_b2: got %0d expected -196608", bus.o_b[2]); end
        n_assert++; if (bus.o_err !== 64'sd393216) begin n_fail++; $display("FAIL three_err: got %0d expected 393216", bus.o_err); end
        n_assert++; if (bus.o_cnt !== 20'd3) begin n_fail++; $display("FAIL three_cnt: got %0d expected 3", bus.o_cnt); end
      end
    end
    n_assert++; if (dones !== 1) begin n_fail++; $display("FAIL three_done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_restart();
    int dones = 0;
    logic [19:0] cap_cnt = '0;
    logic signed [63:0] cap_h = '0;
    for (int c = 0; c < 14; c++) begin
      clear_main();
      if (c < 7) begin
        bus.i_valid       = 1;
        bus.i_frame_start = (c == 0 || c == 5);
        bus.i_frame_end   = (c == 6);
        bus.i_Ax[0]       = 42'sd65536;
      end
      step();
      if (bus.o_done === 1'b1) begin dones++; cap_cnt = bus.o_cnt; cap_h = bus.o_H[0]; end
    end
    n_assert++; if (dones !== 1) begin n_fail++; $display("FAIL restart_done_count: got %0d expected 1", dones); end
    n_assert++; if (cap_cnt !== 20'd2) begin n_fail++; $display("FAIL restart_cnt: got %0d expected 2", cap_cnt); end
    n_assert++; if (cap_h !== 64'sd131072) begin n_fail++; $display("FAIL restart_H00: got %0d expected 131072", cap_h); end
  endtask

  task automatic test_reset_mid_frame();
    int dones = 0;
    for (int c = 0; c < 12; c++) begin
      clear_main();
      rst = (c == 3);
      if (c < 3 || c == 4) begin
        bus.i_valid       = 1;
        bus.i_frame_start = (c == 0);
        bus.i_frame_end   = (c == 4);
        bus.i_Ax[0]       = 42'sd65536;
        bus.i_diffs_x     = 42'sd65536;
      end
      step();
      if (bus.o_done === 1'b1) dones++;
    end
    rst = 0;
    n_assert++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_done_count: got %0d expected 0", dones); end
    n_assert++; if (bus.o_H[0] !== 64'sd0) begin n_fail++; $display("FAIL rstmid_H00: got %0d expected 0", bus.o_H[0]); end
    n_assert++; if (bus.o_b[0] !== 64'sd0) begin n_fail++; $display("FAIL rstmid_b0: got %0d expected 0", bus.o_b[0]); end
    n_assert++; if (bus.o_err !== 64'sd0) begin n_fail++; $display("FAIL rstmid_err: got %0d expected 0", bus.o_err); end
    n_assert++; if (bus.o_cnt !== 20'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d expected 0", bus.o_cnt); end
    n_assert++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.o_busy); end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    logic [19:0] cap_cnt [2];
    logic signed [63:0] cap_h [2];
    cap_cnt = '{default: '0};
    cap_h   = '{default: '0};
    for (int c = 0; c < 14; c++) begin
      clear_main();
      if (c < 5) begin
        bus.i_valid       = 1;
        bus.i_frame_start = (c == 0 || c == 2);
        bus.i_frame_end   = (c == 1 || c == 4);
        bus.i_Ax[0]       = 42'sd65536;
      end
      step();
      if (bus.o_done === 1'b1) begin
        if (dones < 2) begin cap_cnt[dones] = bus.o_cnt; cap_h[dones] = bus.o_H[0]; end
        dones++;
      end
    end
    n_assert++; if (dones !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", dones); end
    n_assert++; if (cap_cnt[0] !== 20'd2) begin n_fail++; $display("FAIL b2b_cnt_a: got %0d expected 2", cap_cnt[0]); end
    n_assert++; if (cap_cnt[1] !== 20'd3) begin n_fail++; $display("FAIL b2b_cnt_b: got %0d expected 3", cap_cnt[1]); end
    n_assert++; if (cap_h[0] !== 64'sd131072) begin n_fail++; $display("FAIL b2b_H00_a: got %0d expected 131072", cap_h[0]); end
    n_assert++; if (cap_h[1] !== 64'sd196608) begin n_fail++; $display("FAIL b2b_H00_b: got %0d expected 196608", cap_h[1]); end
  endtask

  task automatic test_saturation();
    int dones = 0;
    logic signed [39:0] cap_h = '0, cap_b = '0, cap_err = '0;
    logic [19:0] cap_cnt = '0;
    // Positive saturation over a long frame; b stays zero because dx=dy=0.
    for (int c = 0; c < 1008; c++) begin
      clear_40();
      if (c < 1000) begin
        bus40.i_valid       = 1;
        bus40.i_frame_start = (c == 0);
        bus40.i_frame_end   = (c == 999);
        bus40.i_Ax[0]       = 42'sd1073741824;
        bus40.i_Ay[0]       = 42'sd1073741824;
      end
      step();
      if (c == 3) begin
        n_assert++; if (bus40.o_H[0] !== MAX40) begin n_fail++; $display("FAIL sat_H00_mid: got %0d expected %0d", bus40.o_H[0], MAX40); end
      end
      if (bus40.o_done === 1'b1) begin
        dones++; cap_h = bus40.o_H[0]; cap_b = bus40.o_b[0]; cap_cnt = bus40.o_cnt;
      end
    end
    n_assert++; if (dones !== 1) begin n_fail++; $display("FAIL sat_done_count: got %0d expected 1", dones); end
    n_assert++; if (cap_h !== MAX40) begin n_fail++; $display("FAIL sat_H00: got %0d expected %0d", cap_h, MAX40); end
    n_assert++; if (cap_b !== 40'sd0) begin n_fail++; $display("FAIL sat_b0: got %0d expected 0", cap_b); end
    n_assert++; if (cap_cnt !== 20'd1000) begin n_fail++; $display("FAIL sat_cnt: got %0d expected 1000", cap_cnt); end
    // Negative saturation of b, positive of err.
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      clear_40();
      if (c < 3) begin
        bus40.i_valid       = 1;
        bus40.i_frame_start = (c == 0);
        bus40.i_frame_end   = (c == 2);
        bus40.i_Ax[0]       = 42'sd1073741824;
        bus40.i_diffs_x     = -42'sd1073741824;
      end
      step();
      if (bus40.o_done === 1'b1) begin
        dones++; cap_b = bus40.o_b[0]; cap_err = bus40.o_err; cap_cnt = bus40.o_cnt;
      end
    end
    n_assert++; if (dones !== 1) begin n_fail++; $display("FAIL satneg_done_count: got %0d expected 1", dones); end
    n_assert++; if (cap_b !== MIN40) begin n_fail++; $display("FAIL satneg_b0: got %0d expected %0d", cap_b, MIN40); end
    n_assert++; if (cap_err !== MAX40) begin n_fail++; $display("FAIL satneg_err: got %0d expected %0d", cap_err, MAX40); end
    n_assert++; if (cap_cnt !== 20'd3) begin n_fail++; $display("FAIL satneg_cnt: got %0d expected 3", cap_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_sample();
    test_restart();
    test_reset_mid_frame();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
